// File: rtl/key_filter.sv
// Push-button debouncer: 3-flop synchronizer plus a stable-time window FSM that
// emits a clean level, a one-cycle event pulse and a wrapping press counter.
module key_filter #(
    parameter int CNT_MAX = 999_999,
    parameter int CNT_W   = 20
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       key_in,
    output logic       key_flag,
    output logic       key_state,
    output logic [7:0] press_cnt
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FILT_DN = 2'd1,
        DOWN    = 2'd2,
        FILT_UP = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX);

    state_t           state;
    logic [CNT_W-1:0] counter;
    logic             s0;
    logic             s1;
    logic             s2;
    logic             nedge;
    logic             pedge;

    // Synchronizer: s0 may go metastable, edges are taken from s1/s2 only.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            s0 <= 1'b1;
            s1 <= 1'b1;
            s2 <= 1'b1;
        end else begin
            s0 <= key_in;
            s1 <= s0;
            s2 <= s1;
        end
    end

    assign nedge = s2 & ~s1;
    assign pedge = ~s2 & s1;

    // Filter FSM: any opposite edge inside a window aborts it, even on the
    // cycle the window would otherwise complete.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state     <= IDLE;
            counter   <= '0;
            key_flag  <= 1'b0;
            key_state <= 1'b1;
            press_cnt <= 8'd0;
        end else begin
            key_flag <= 1'b0;
            case (state)
                IDLE: begin
                    counter <= '0;
                    if (nedge) begin
                        state <= FILT_DN;
                    end
                end
                FILT_DN: begin
                    if (pedge) begin
                        state   <= IDLE;
                        counter <= '0;
                    end else if (counter == CNT_LAST) begin
                        state     <= DOWN;
                        counter   <= '0;
                        key_flag  <= 1'b1;
                        key_state <= 1'b0;
                        press_cnt <= press_cnt + 8'd1;
                    end else begin
                        counter <= counter + CNT_W'(1);
                    end
                end
                DOWN: begin
                    counter <= '0;
                    if (pedge) begin
                        state <= FILT_UP;
                    end
                end
                FILT_UP: begin
                    if (nedge) begin
                        state   <= DOWN;
                        counter <= '0;
                    end else if (counter == CNT_LAST) begin
                        state     <= IDLE;
                        counter   <= '0;
                        key_flag  <= 1'b1;
                        key_state <= 1'b1;
                    end else begin
                        counter <= counter + CNT_W'(1);
                    end
                end
                default: begin
                    state   <= IDLE;
                    counter <= '0;
                end
            endcase
        end
    end

endmodule

// File: doc/key_filter.md
Name: key_filter

Overview:
- Synthesizable debouncer for one mechanical push-button input.
- Sits between the board key pin and user logic.
- It is the receiving end of the bouncing-key simulation model. That model toggles the key line up to 50 times with random gaps of up to 65 µs, then holds the level stable for 50 ms.
- Filters bounce with a stable-time window and emits a clean level, a one-cycle press/release event and a wrapping press counter.

Parameters:
- CNT_MAX, 999_999, stable-window length minus 1 in clocks (20 ms at 50 MHz).
- CNT_W, 20, width of the window counter; must satisfy 2^CNT_W > CNT_MAX.

Ports:
- Clk  input  1  system clock (50 MHz nominal).
- Rst  input  1  synchronous reset, active-high.
- key_in  input  1  raw asynchronous key level; 1 = released, 0 = pressed.
- key_flag  output  1  one-cycle pulse on every confirmed press or release.
- key_state  output  1  debounced level; 1 = released, 0 = pressed.
- press_cnt  output  8  count of confirmed presses; wraps 255 -> 0.

Behaviour:
- Reset values (all synchronous, applied on the first Clk edge with Rst = 1):
  - key_flag = 0, key_state = 1, press_cnt = 0.
  - state = IDLE, counter = 0.
  - sync regs s0/s1/s2 = 1.
- Synchronizer:
  - s0 <= key_in, s1 <= s0, s2 <= s1.
  - nedge = s2 & ~s1 (combinational); pedge = ~s2 & s1.
- FSM states: IDLE (released, stable), FILT_DN, DOWN (pressed, stable), FILT_UP.
- IDLE:
  - nedge -> FILT_DN, counter <= 0.
  - Otherwise stay.
- FILT_DN:
  - pedge -> IDLE, counter <= 0, no flag.
  - Else if counter == CNT_MAX -> DOWN; key_flag <= 1, key_state <= 0, press_cnt <= press_cnt + 1, counter <= 0.
  - Else counter <= counter + 1.
- DOWN:
  - pedge -> FILT_UP, counter <= 0.
- FILT_UP (mirror of FILT_DN):
  - nedge -> DOWN, no flag.
  - Else if counter == CNT_MAX -> IDLE; key_flag <= 1, key_state <= 1.
  - Else counter <= counter + 1.
- key_flag is high for exactly one clock per transition and is 0 in every other cycle.
- Simultaneous events: an opposite edge arriving in the same cycle as counter == CNT_MAX aborts the window. No flag is issued.
- Latency: let E0 be the Clk edge that first samples the final stable low level. key_flag and key_state change on edge E0 + CNT_MAX + 3, provided there is no further bounce. The same latency applies to release.
- Every bounce inside a window restarts filtering from zero. A pulse shorter than CNT_MAX + 1 clocks never changes key_state.
- Counter is held at 0 in IDLE and DOWN; it never exceeds CNT_MAX.
- press_cnt increments only on a confirmed press, 8-bit modulo.
- Reset mid-operation (including mid-window): all outputs return to reset values on the next edge; no flag is generated.
- If key_in is low while Rst deasserts, the synchronizer produces an nedge. A normal press is then confirmed after the window.

Test Plan:
All scenarios use CNT_MAX = 999 and a 50 MHz Clk.
- Reset check: hold Rst 5 cycles, key_in = 1 -> key_flag = 0, key_state = 1, press_cnt = 0, no flag for 3000 cycles.
- Clean press:
  - Stimulus: key_in 1 -> 0 at edge E0 and held.
  - Response: single key_flag pulse at E0 + 1002; key_state = 0 from that edge; press_cnt = 1.
- Bouncy press then release:
  - Stimulus: 20 toggles with gaps of 10–900 cycles, then stable low for 5000 cycles; then 20 toggles, then stable high for 5000 cycles.
  - Response: exactly two flags. The first comes 1002 cycles after the last falling sample and sets key_state = 0. The second comes 1002 cycles after the last rising sample and sets key_state = 1. press_cnt = 1.
- Glitch rejection:
  - Stimulus: low pulse of 999 cycles, then a low pulse of 1 cycle.
  - Response: no key_flag; key_state stays 1.
- Boundary: a rising edge coinciding with counter == 999 in FILT_DN -> no flag, state returns to IDLE.
- Wrap and reset:
  - Stimulus: 256 clean presses, then 1 more press. Assert Rst for 1 cycle midway through a FILT_DN window.
  - Response: press_cnt reaches 0 after the 256th press and 1 after the next. After the reset, press_cnt = 0, key_state = 1, and there is no flag.
